mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control FSM of the multi-cycle, non-pipelined MIPS core. Decodes op from the instruction register.
//  Sequences fetch/decode/execute/memory/writeback and drives all datapath enables and mux selects.
//  Supersedes the R-type-only decode with a full core opcode set and a memory ready handshake.
//  Adds a bounded wait-state timeout with a sticky error.
// PARAMETERS
//  WAIT_TIMEOUT  255  max consecutive cycles mem_req=1 && mem_ready=0 before ERROR; 0 = no timeout
//  CNT_WIDTH     8    timeout counter width; must satisfy 2**CNT_WIDTH > WAIT_TIMEOUT
// PORTS
//  clk            in   1  core clock
//  rst            in   1  asynchronous reset, active-high
//  op             in   6  mips_op_e from instruction register [31:26]
//  mem_ready      in   1  memory completes current access this cycle
//  mem_req        out  1  memory access request, held until mem_ready
//  mem_we         out  1  write access (valid with mem_req)
//  i_or_d         out  1  0 = address from PC, 1 = address from ALUOut
//  ir_write       out  1  load instruction register
//  pc_write       out  1  unconditional PC update
//  branch_eq      out  1  PC update if ALU zero (beq)
//  branch_ne      out  1  PC update if ALU non-zero (bne)
//  pc_src         out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
//  alu_src_a      out  1  0 = PC, 1 = register A
//  alu_src_b      out  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
//  alu_class      out  2  mips_alu_class_e: ADD, SUB, FUNCT
//  reg_dst        out  1  0 = rt, 1 = rd
//  mem_to_reg     out  1  0 = ALUOut, 1 = MDR
//  reg_write      out  1  register file write enable
//  instr_done     out  1  one-cycle pulse on the last cycle of each instruction
//  err            out  1  sticky: timeout or illegal opcode
//  state          out  4  current mips_ctrl_state_e (debug)
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0 during reset and in IDLE.
//  - IDLE->FETCH unconditionally on the first clock after reset deassertion.
//  - Moore outputs decoded from state; ir_write/pc_write in FETCH are additionally gated by mem_ready.
//  - FETCH: mem_req=1, i_or_d=0, src_a=0, src_b=1, class=ADD, pc_src=0.
//    Stays in FETCH while !mem_ready; on mem_ready: ir_write=1, pc_write=1, go to DECODE.
//  - DECODE: src_a=0, src_b=3, class=ADD (branch target into ALUOut); next state by op:
//      LW/SW->MEM_ADDR, RTYPE->EXECUTE, BEQ/BNE->BRANCH, ADDI->ADDI_EXEC, J->JUMP, else->ERROR
//  - MEM_ADDR: src_a=1, src_b=2, ADD; ->MEM_READ (LW) or MEM_WRITE (SW).
//  - MEM_READ: mem_req=1, i_or_d=1; wait for mem_ready ->MEM_WB.
//  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 ->FETCH.
//  - MEM_WRITE: mem_req=1, mem_we=1, i_or_d=1; on mem_ready instr_done=1 ->FETCH.
//  - EXECUTE: src_a=1, src_b=0, FUNCT ->ALU_WB. ALU_WB: reg_write=1, reg_dst=1, instr_done=1 ->FETCH.
//  - BRANCH: src_a=1, src_b=0, SUB, pc_src=1, branch_eq (BEQ) or branch_ne (BNE), instr_done=1 ->FETCH.
//  - ADDI_EXEC: src_a=1, src_b=2, ADD ->ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, instr_done=1 ->FETCH.
//  - JUMP: pc_write=1, pc_src=2, instr_done=1 ->FETCH.
//  - ERROR: terminal, all outputs 0 except err=1 and state; only rst exits.
//  - Cycles at zero wait: R=4, LW=5, SW=4, BEQ/BNE=3, ADDI=4, J=3. Each wait cycle adds 1.
//  - Timeout counter: clears when mem_req=0 or mem_ready=1, else increments, saturating.
//    Reaching WAIT_TIMEOUT forces ERROR next cycle, even in the same cycle mem_ready rises? No: mem_ready wins.
//  - Reset mid-instruction: async return to IDLE, counter=0, err=0. No partial write is issued after rst.
// CONFIGURATION
//  MIPS_CTRL_BNE_EN defined: op BNE (000101) decodes to BRANCH with branch_ne.
//  Not defined: BNE is illegal and goes to ERROR; branch_ne is tied to 0.
// STRUCTURE
//  MIPS_pkg gains:
//    mips_op_e: LW=100011, SW=101011, BEQ=000100, BNE=000101, ADDI=001000, J=000010
//    mips_ctrl_state_e (4-bit) and mips_alu_class_e
//  Sub-module mips_mem_wait_timer: counter plus timeout compare, output `expired`.
// TESTING
//  - rst high 3 cycles, release, op=RTYPE, mem_ready=1 -> IDLE,FETCH,DECODE,EXECUTE,ALU_WB; reg_write+reg_dst=1 at cycle 5.
//  - LW with mem_ready low 2 cycles in MEM_READ -> 7 cycles total; reg_write+mem_to_reg exactly once.
//  - BEQ then J, no wait -> branch_eq pulse in cycle 3; pc_write+pc_src=2 in cycle 3 of J; two instr_done pulses.
//  - op=6'b111111 -> ERROR after DECODE; err=1 and stays 1 for 100 cycles; rst clears it.
//  - WAIT_TIMEOUT=4, mem_ready held 0 in FETCH -> ERROR after 4 wait cycles.
//    Same bench with mem_ready at wait 4 -> no error.
//  - op=BNE in both builds -> with MIPS_CTRL_BNE_EN: branch_ne=1 in BRANCH; without it: ERROR.
//  - rst pulse during MEM_WRITE wait -> mem_req/mem_we drop immediately.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS main controller: opcodes, FSM states,
// ALU operation classes and the registered control-output bundle.
package mips_multicycle_ctrl_pkg;

  localparam int unsigned OP_W        = 6;
  localparam int unsigned STATE_W     = 4;
  localparam int unsigned PC_SRC_W    = 2;
  localparam int unsigned ALU_SRC_B_W = 2;
  localparam int unsigned ALU_CLASS_W = 2;

  // Opcode field, instruction register bits [31:26]
  typedef enum logic [OP_W-1:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } mips_op_e;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JUMP      = 4'd12,
    S_ERROR     = 4'd13
  } mips_ctrl_state_e;

  typedef enum logic [ALU_CLASS_W-1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } mips_alu_class_e;

  // Moore outputs, decoded from the next state and held in flops
  typedef struct packed {
    logic                   mem_req;
    logic                   mem_we;
    logic                   i_or_d;
    logic                   pc_write;
    logic                   branch_eq;
    logic                   branch_ne;
    logic [PC_SRC_W-1:0]    pc_src;
    logic                   alu_src_a;
    logic [ALU_SRC_B_W-1:0] alu_src_b;
    mips_alu_class_e        alu_class;
    logic                   reg_dst;
    logic                   mem_to_reg;
    logic                   reg_write;
    logic                   instr_done;
    logic                   err;
  } mips_ctrl_out_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath side.
interface mips_multicycle_ctrl_if;
  import mips_multicycle_ctrl_pkg::*;

  logic [OP_W-1:0]        op;
  logic                   mem_ready;
  logic                   mem_req;
  logic                   mem_we;
  logic                   i_or_d;
  logic                   ir_write;
  logic                   pc_write;
  logic                   branch_eq;
  logic                   branch_ne;
  logic [PC_SRC_W-1:0]    pc_src;
  logic                   alu_src_a;
  logic [ALU_SRC_B_W-1:0] alu_src_b;
  logic [ALU_CLASS_W-1:0] alu_class;
  logic                   reg_dst;
  logic                   mem_to_reg;
  logic                   reg_write;
  logic                   instr_done;
  logic                   err;
  logic [STATE_W-1:0]     state;

  modport master (
    input  op, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, branch_eq, branch_ne,
           pc_src, alu_src_a, alu_src_b, alu_class, reg_dst, mem_to_reg,
           reg_write, instr_done, err, state
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, branch_eq, branch_ne,
           pc_src, alu_src_a, alu_src_b, alu_class, reg_dst, mem_to_reg,
           reg_write, instr_done, err, state
  );

endinterface

// File: rtl/mips_mem_wait_timer.sv
// Counts consecutive memory wait cycles (req high, ready low). 'expired' flags
// the WAIT_TIMEOUT-th consecutive wait cycle so the FSM can leave for ERROR on
// the next edge; a ready in that cycle is not a wait, so ready always wins.
// WAIT_TIMEOUT = 0 disables the timeout.
module mips_mem_wait_timer #(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  output logic expired
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] LAST_WAIT =
    CNT_WIDTH'((WAIT_TIMEOUT == 32'd0) ? 32'd0 : WAIT_TIMEOUT - 32'd1);

  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 waiting;

  // Saturating wait counter; any non-wait cycle clears it
  always_comb begin
    waiting = req & ~ready;
    cnt_d   = '0;
    if (waiting) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    end
    expired = (WAIT_TIMEOUT != 32'd0) && waiting && (cnt_q == LAST_WAIT);
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core. Sequences fetch, decode,
// execute, memory and writeback, with a memory-ready handshake and a bounded
// wait timeout that lands in a sticky ERROR state.
// Build option: define MIPS_CTRL_BNE_EN to decode BNE; otherwise BNE is an
// illegal opcode and branch_ne stays 0.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_multicycle_ctrl_if.master bus
);

  mips_ctrl_state_e state_d, state_q;
  mips_ctrl_out_t   out_d, out_q;
  logic             expired;
  logic             in_fetch;
  logic             in_mem_write;

  mips_mem_wait_timer #(
    .WAIT_TIMEOUT (WAIT_TIMEOUT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .req     (out_q.mem_req),
    .ready   (bus.mem_ready),
    .expired (expired)
  );

  // Next state and next Moore outputs (outputs decoded from the next state)
  always_comb begin
    state_d = state_q;
    out_d   = '0;

    case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)   state_d = S_DECODE;
        else if (expired)    state_d = S_ERROR;
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEM_ADDR:  state_d = (bus.op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (bus.mem_ready)   state_d = S_MEM_WB;
        else if (expired)    state_d = S_ERROR;
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready)   state_d = S_FETCH;
        else if (expired)    state_d = S_ERROR;
      end
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP: state_d = S_FETCH;
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_ERROR;
    endcase

    case (state_d)
      S_FETCH: begin
        out_d.mem_req   = 1'b1;
        out_d.alu_src_b = 2'd1;
      end
      S_DECODE: begin
        out_d.alu_src_b = 2'd3;
      end
      S_MEM_ADDR: begin
        out_d.alu_src_a = 1'b1;
        out_d.alu_src_b = 2'd2;
      end
      S_MEM_READ: begin
        out_d.mem_req = 1'b1;
        out_d.i_or_d  = 1'b1;
      end
      S_MEM_WB: begin
        out_d.reg_write  = 1'b1;
        out_d.mem_to_reg = 1'b1;
        out_d.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        out_d.mem_req = 1'b1;
        out_d.mem_we  = 1'b1;
        out_d.i_or_d  = 1'b1;
      end
      S_EXECUTE: begin
        out_d.alu_src_a = 1'b1;
        out_d.alu_class = ALU_FUNCT;
      end
      S_ALU_WB: begin
        out_d.reg_write  = 1'b1;
        out_d.reg_dst    = 1'b1;
        out_d.instr_done = 1'b1;
      end
      S_BRANCH: begin
        out_d.alu_src_a  = 1'b1;
        out_d.alu_class  = ALU_SUB;
        out_d.pc_src     = 2'd1;
        out_d.branch_eq  = (bus.op == OP_BEQ);
`ifdef MIPS_CTRL_BNE_EN
        out_d.branch_ne  = (bus.op == OP_BNE);
`endif
        out_d.instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        out_d.alu_src_a = 1'b1;
        out_d.alu_src_b = 2'd2;
      end
      S_ADDI_WB: begin
        out_d.reg_write  = 1'b1;
        out_d.instr_done = 1'b1;
      end
      S_JUMP: begin
        out_d.pc_write   = 1'b1;
        out_d.pc_src     = 2'd2;
        out_d.instr_done = 1'b1;
      end
      S_ERROR: begin
        out_d.err = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Handshake-completion strobes must land in the same cycle mem_ready arrives
  assign in_fetch     = (state_q == S_FETCH);
  assign in_mem_write = (state_q == S_MEM_WRITE);

  assign bus.ir_write   = in_fetch & bus.mem_ready;
  assign bus.pc_write   = out_q.pc_write | (in_fetch & bus.mem_ready);
  assign bus.instr_done = out_q.instr_done | (in_mem_write & bus.mem_ready);

  assign bus.mem_req    = out_q.mem_req;
  assign bus.mem_we     = out_q.mem_we;
  assign bus.i_or_d     = out_q.i_or_d;
  assign bus.branch_eq  = out_q.branch_eq;
  assign bus.branch_ne  = out_q.branch_ne;
  assign bus.pc_src     = out_q.pc_src;
  assign bus.alu_src_a  = out_q.alu_src_a;
  assign bus.alu_src_b  = out_q.alu_src_b;
  assign bus.alu_class  = out_q.alu_class;
  assign bus.reg_dst    = out_q.reg_dst;
  assign bus.mem_to_reg = out_q.mem_to_reg;
  assign bus.reg_write  = out_q.reg_write;
  assign bus.err        = out_q.err;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl (WAIT_TIMEOUT = 4). Honours MIPS_CTRL_BNE_EN
// the same way the design does.
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;

  localparam int unsigned TB_TIMEOUT = 4;

  typedef struct packed {
    mips_ctrl_state_e st;
    logic [18:0]      outs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_rw, n_m2r, n_done, n_beq, n_bne, n_jmp;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(
    .WAIT_TIMEOUT (TB_TIMEOUT),
    .CNT_WIDTH    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [18:0] obs_outs();
    return {bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_write, bus.pc_write,
            bus.branch_eq, bus.branch_ne, bus.pc_src, bus.alu_src_a, bus.alu_src_b,
            bus.alu_class, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
            bus.instr_done, bus.err};
  endfunction

  // Reference output table per state, written straight from the control table
  function automatic logic [18:0] exp_outs(input mips_ctrl_state_e s, input logic rdy, input logic bne);
    logic       req = 1'b0, we = 1'b0, iod = 1'b0, irw = 1'b0, pcw = 1'b0;
    logic       beq = 1'b0, bnp = 1'b0, srca = 1'b0, rdst = 1'b0, m2r = 1'b0;
    logic       rw = 1'b0, done = 1'b0, e = 1'b0;
    logic [1:0] pcs = 2'd0, srcb = 2'd0, cls = 2'd0;
    case (s)
      S_FETCH:     begin req = 1'b1; srcb = 2'd1; irw = rdy; pcw = rdy; end
      S_DECODE:    begin srcb = 2'd3; end
      S_MEM_ADDR:  begin srca = 1'b1; srcb = 2'd2; end
      S_MEM_READ:  begin req = 1'b1; iod = 1'b1; end
      S_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
      S_MEM_WRITE: begin req = 1'b1; we = 1'b1; iod = 1'b1; done = rdy; end
      S_EXECUTE:   begin srca = 1'b1; cls = 2'd2; end
      S_ALU_WB:    begin rw = 1'b1; rdst = 1'b1; done = 1'b1; end
      S_BRANCH:    begin srca = 1'b1; cls = 2'd1; pcs = 2'd1; beq = ~bne; bnp = bne; done = 1'b1; end
      S_ADDI_EXEC: begin srca = 1'b1; srcb = 2'd2; end
      S_ADDI_WB:   begin rw = 1'b1; done = 1'b1; end
      S_JUMP:      begin pcw = 1'b1; pcs = 2'd2; done = 1'b1; end
      S_ERROR:     begin e = 1'b1; end
      default: ;
    endcase
    return {req, we, iod, irw, pcw, beq, bnp, pcs, srca, srcb, cls, rdst, m2r, rw, done, e};
  endfunction

  // Drive one cycle: push the expectation, compare when the DUT shows it
  task automatic step(input mips_ctrl_state_e s, input logic rdy);
    exp_t e;
    bus.mem_ready = rdy;
    sb_q.push_back('{st: s, outs: exp_outs(s, rdy, bus.op == OP_BNE)});
    @(negedge clk);
    e = sb_q.pop_front();
    check_eq("state", 32'(bus.state), 32'(e.st));
    check_eq("outputs", 32'(obs_outs()), 32'(e.outs));
    if (bus.reg_write) n_rw++;
    if (bus.reg_write && bus.mem_to_reg) n_m2r++;
    if (bus.instr_done) n_done++;
    if (bus.branch_eq) n_beq++;
    if (bus.branch_ne) n_bne++;
    if (bus.pc_write && bus.pc_src == 2'd2) n_jmp++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_rw = 0; n_m2r = 0; n_done = 0; n_beq = 0; n_bne = 0; n_jmp = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step(S_IDLE, 1'b1);
    rst = 1'b0;
    step(S_IDLE, 1'b1);
  endtask

  task automatic instr_r();
    bus.op = OP_RTYPE;
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_EXECUTE, 1'b1); step(S_ALU_WB, 1'b1);
  endtask

  task automatic instr_lw(input int waits);
    bus.op = OP_LW;
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_MEM_ADDR, 1'b1);
    for (int i = 0; i < waits; i++) step(S_MEM_READ, 1'b0);
    step(S_MEM_READ, 1'b1); step(S_MEM_WB, 1'b1);
  endtask

  task automatic instr_sw(input int waits);
    bus.op = OP_SW;
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_MEM_ADDR, 1'b1);
    for (int i = 0; i < waits; i++) step(S_MEM_WRITE, 1'b0);
    step(S_MEM_WRITE, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus.op = OP_RTYPE;
    bus.mem_ready = 1'b1;
    clr_counts();

    // Reset for 3 cycles, then R-type: IDLE,FETCH,DECODE,EXECUTE,ALU_WB
    do_reset(3);
    instr_r();
    check_eq("r_reg_write_cnt", 32'(n_rw), 32'd1);
    check_eq("r_done_cnt", 32'(n_done), 32'd1);

    // LW with two wait cycles in MEM_READ: 7 cycles
    clr_counts();
    instr_lw(2);
    check_eq("lw_mem_to_reg_cnt", 32'(n_m2r), 32'd1);
    check_eq("lw_reg_write_cnt", 32'(n_rw), 32'd1);

    // BEQ then J, no waits
    clr_counts();
    bus.op = OP_BEQ;
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_BRANCH, 1'b1);
    bus.op = OP_J;
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_JUMP, 1'b1);
    check_eq("beq_pulse_cnt", 32'(n_beq), 32'd1);
    check_eq("jump_pulse_cnt", 32'(n_jmp), 32'd1);
    check_eq("beq_j_done_cnt", 32'(n_done), 32'd2);

    // SW with one wait, then ADDI
    clr_counts();
    instr_sw(1);
    bus.op = OP_ADDI;
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_ADDI_EXEC, 1'b1); step(S_ADDI_WB, 1'b1);
    check_eq("sw_addi_done_cnt", 32'(n_done), 32'd2);

    // Three waits in MEM_READ stay under the limit
    instr_lw(3);

    // FETCH: ready arrives where the 4th wait would be -> ready wins
    bus.op = OP_RTYPE;
    for (int i = 0; i < 3; i++) step(S_FETCH, 1'b0);
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_EXECUTE, 1'b1); step(S_ALU_WB, 1'b1);

    // Async reset during a MEM_WRITE wait drops the write request at once
    clr_counts();
    bus.op = OP_SW;
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_MEM_ADDR, 1'b1);
    step(S_MEM_WRITE, 1'b0); step(S_MEM_WRITE, 1'b0);
    bus.mem_ready = 1'b0;
    check_eq("mw_req_before_rst", 32'(bus.mem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("mw_req_after_rst", 32'(bus.mem_req), 32'd0);
    check_eq("mw_we_after_rst", 32'(bus.mem_we), 32'd0);
    check_eq("mw_state_after_rst", 32'(bus.state), 32'(S_IDLE));
    do_reset(2);
    check_eq("mw_no_done", 32'(n_done), 32'd0);
    instr_r();

    // FETCH timeout: four wait cycles -> ERROR
    bus.op = OP_RTYPE;
    for (int i = 0; i < 4; i++) step(S_FETCH, 1'b0);
    for (int i = 0; i < 3; i++) step(S_ERROR, 1'($urandom_range(0, 1)));

    // MEM_READ timeout: four wait cycles -> ERROR
    do_reset(2);
    bus.op = OP_LW;
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_MEM_ADDR, 1'b1);
    for (int i = 0; i < 4; i++) step(S_MEM_READ, 1'b0);
    step(S_ERROR, 1'b1);

    // Illegal opcode -> ERROR, sticky for 100 cycles, cleared by reset
    do_reset(2);
    bus.op = 6'b111111;
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1);
    for (int i = 0; i < 100; i++) step(S_ERROR, 1'($urandom_range(0, 1)));
    do_reset(2);

    // BNE depends on the build option
    clr_counts();
    bus.op = OP_BNE;
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1);
`ifdef MIPS_CTRL_BNE_EN
    step(S_BRANCH, 1'b1);
    check_eq("bne_pulse_cnt", 32'(n_bne), 32'd1);
`else
    step(S_ERROR, 1'b1); step(S_ERROR, 1'b0);
    check_eq("bne_pulse_cnt", 32'(n_bne), 32'd0);
`endif
    do_reset(1);
    instr_r();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
